// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/sub: one CHUNK-bit slice per stage, result after STAGES-1 edges past acceptance.
// Backpressure: a single advance (adv = !out_valid || out_ready) freezes every stage; in_ready = adv.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    // Returns {carry out, carry into slice MSB, sum}; every carry is a flat
    // sum-of-products over generate/propagate rather than a ripple chain.
    function automatic logic [CHUNK+1:0] cla_slice(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        logic             term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
            term = ci;
            for (int m = 0; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
        end
        return {c[CHUNK], c[CHUNK-1], p ^ c[CHUNK-1:0]};
    endfunction

    // Per-stage registers: operands carry the not-yet-resolved upper slices,
    // s_r accumulates the finished lower slices so a result leaves as one word.
    logic             v_r [STAGES];
    logic             c_r [STAGES];
    logic [WIDTH-1:0] a_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic [WIDTH-1:0] s_r [STAGES];
    logic             ovf_r;

    logic             iv    [STAGES];
    logic             ici   [STAGES];
    logic [WIDTH-1:0] ia    [STAGES];
    logic [WIDTH-1:0] ib    [STAGES];
    logic [WIDTH-1:0] iprev [STAGES];
    logic [WIDTH-1:0] ns    [STAGES];
    logic             nc    [STAGES];
    logic             msb_c;
    logic             adv;

    assign out_valid = v_r[STAGES-1];
    assign s         = s_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    assign ovf       = ovf_r;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    always_comb begin
        logic [CHUNK+1:0] r;
        r     = '0;
        msb_c = 1'b0;
        // Subtraction folds into stage 0 as a + ~b + 1, so sub never travels.
        iv[0]    = in_valid;
        ia[0]    = a;
        ib[0]    = sub ? ~b : b;
        ici[0]   = sub | cin;
        iprev[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            iv[k]    = v_r[k-1];
            ia[k]    = a_r[k-1];
            ib[k]    = b_r[k-1];
            ici[k]   = c_r[k-1];
            iprev[k] = s_r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            r     = cla_slice(ia[k][k*CHUNK +: CHUNK], ib[k][k*CHUNK +: CHUNK], ici[k]);
            ns[k] = iprev[k];
            ns[k][k*CHUNK +: CHUNK] = r[CHUNK-1:0];
            nc[k] = r[CHUNK+1];
            if (k == STAGES - 1) msb_c = r[CHUNK];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= 1'b0;
                c_r[k] <= 1'b0;
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
            ovf_r <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= iv[k];
                c_r[k] <= nc[k];
                a_r[k] <= ia[k];
                b_r[k] <= ib[k];
                s_r[k] <= ns[k];
            end
            ovf_r <= nc[STAGES-1] ^ msb_c;
        end
    end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor. It splits a WIDTH-bit operation into CHUNK-bit slices and resolves one slice per pipeline stage, with a registered carry between stages. It replaces the single-bit combinational full-adder cells inside the complex-multiplier partial-product accumulation path. A valid/ready handshake lets it sit between the vedic multiplier array and the real/imaginary combine stage at one result per cycle with backpressure.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK
- CHUNK, 4, bits resolved per stage; STAGES = WIDTH/CHUNK (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand bundle present
- in_ready  out  1  bundle accepted on the edge where in_valid && in_ready
- a  in  WIDTH  operand A (two's complement or unsigned)
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used only when sub=0
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum/difference, modulo 2^WIDTH
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- Stage k (0..STAGES-1) computes slice k, bits [k·CHUNK +: CHUNK], using per-bit generate/propagate and a lookahead carry within the slice. It takes its carry-in from stage k-1's registered carry. Stage 0 takes cin, or 1 when sub=1.
- B inversion happens at input capture. The sub flag is not needed downstream.
- Upper operand slices travel through skew registers until their stage. Completed lower result slices travel through deskew registers so that all slices of one operation leave together.
- The last stage also registers cout and ovf. ovf uses the carry into bit WIDTH-1, which is internal to the last slice.
- Global advance signal: adv = !out_valid || out_ready. Every pipeline register, including the per-stage valid bits, loads only when adv=1. Otherwise all stages hold.
- in_ready = adv, driven combinationally from out_valid and out_ready. There is no combinational path from in_valid to in_ready.
- A stage's valid bit propagates bubbles. Empty stages still shift when adv=1, so bubbles are squeezed out only at the output.
- Results leave in acceptance order. None are dropped or duplicated.
- CHUNK=WIDTH (STAGES=1) degenerates to a single registered CLA.

## Timing
- Reset: while rst=1 at a rising edge, all stage valid bits, s, cout and ovf clear to 0. in_ready reads 1 in the following cycle.
- Reset mid-operation discards all in-flight operations. out_valid is 0 in the cycle after the reset edge.
- Latency: a bundle accepted at edge E appears with out_valid=1 after edge E+STAGES-1, provided no stall occurs. With STAGES=4, that is the 4th edge counting E.
- Throughput: one operation per cycle while out_ready=1.
- Stall: if out_valid=1 and out_ready=0, then s, cout, ovf and out_valid hold stable, and in_ready=0 in the same cycle.
- Simultaneous events: with out_valid=1, out_ready=1 and in_valid=1 on the same edge, the output is consumed and the new bundle is captured on that edge.
- Operands a, b, cin and sub are sampled only on the accepting edge. They may change freely otherwise.
- Wrap-around: s is always modulo 2^WIDTH. cout and ovf carry the out-of-range information.

## Test plan
Parameters for all scenarios: WIDTH=16, CHUNK=4.
- **Reset:** hold rst=1 for 2 cycles with in_valid=1.
  - Required: out_valid=0, s=0x0000, cout=0 and ovf=0 throughout, and in_ready=1 after release.
  - Required: no output appears for operands driven during reset.
- **Carry ripple across all slices:** a=0xFFFF, b=0x0001, cin=0, sub=0.
  - Required: after 4 edges, s=0x0000, cout=1, ovf=0.
  - Then a=0x00FF, b=0x0000, cin=1 → s=0x0100, cout=0.
- **Signed overflow, add:** a=0x7FFF, b=0x0001 → s=0x8000, cout=0, ovf=1.
  - Then a=0x8000, b=0x8000 → s=0x0000, cout=1, ovf=1.
- **Subtract:** a=0x0005, b=0x0007, sub=1, cin=1 → s=0xFFFE, cout=0, ovf=0.
  - Then a=0x8000, b=0x0001, sub=1 → s=0x7FFF, cout=1, ovf=1.
- **Streaming with backpressure:** 10 back-to-back random bundles; drop out_ready for 3 cycles after the 2nd result.
  - Required: results match the reference model, arrive in order with no loss or duplication, and stay stable while stalled.
  - Required: in_ready=0 exactly during the stall cycles.
- **Reset mid-flight:** accept 3 bundles, then assert rst for 1 cycle.
  - Required: out_valid=0 after the reset edge, and none of the 3 results ever appears.
  - Then a new bundle, a=0x1234 + b=0x1111, yields s=0x2345 after 4 edges.
